fixed_point_seq_unit: RTL and testbench
=======================================

Name: fixed_point_seq_unit

Overview:
Parametrised, multi-cycle successor to the combinational fixed-point unit. Performs ADD, SUB, MUL and SQRT on unsigned Q(WIDTH-FBITS).FBITS operands using a start/busy/ready handshake. MUL uses a shift-add datapath and SQRT a digit-by-digit iterator, so no wide combinational multiplier or loop is inferred. Sits beside the integer ALU in the execute stage; the pipeline stalls while busy is high.

Parameters:
WIDTH, 32, operand/result width in bits (>= 8)
FBITS, 10, fractional bits; WIDTH+FBITS must be even (elaboration error otherwise)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only when busy=0
operation  input  2  FPU_ADD=0, FPU_SUB=1, FPU_MUL=2, FPU_SQRT=3
operand_1  input  WIDTH  first operand (radicand for SQRT)
operand_2  input  WIDTH  second operand (ignored for SQRT)
result  output  WIDTH  registered result, held until next completion
ready  output  1  one-cycle pulse, result valid
busy  output  1  high from cycle after accepted start until ready pulse

Behaviour:
- Clocking/reset: one clock domain; reset is synchronous and active-high on clk. Reset: state=IDLE, result=0, ready=0, busy=0, internal accumulators cleared. Reset mid-operation aborts it with no ready pulse.
- States: IDLE, MUL, SQRT, DONE.
- Operands and operation are latched on the accepting edge; later input changes have no effect.
- start while busy=1 is ignored, not queued.
- IDLE, start=1, ADD/SUB: result <= operand_1 +/- operand_2 (mod 2^WIDTH). Go to DONE. Latency is 1: ready is high in the cycle after start.
- IDLE, start=1, MUL: load multiplicand, multiplier and 2*WIDTH-bit accumulator=0. Go to MUL with count=WIDTH.
- MUL state: one multiplier bit per cycle (LSB first); add the shifted multiplicand when the bit is 1. After WIDTH iterations, result <= product[WIDTH+FBITS-1:FBITS] (truncate, no rounding). Go to DONE.
- MUL latency is WIDTH+1 cycles from start to ready.
- IDLE, start=1, SQRT: radicand = operand_1 << FBITS (WIDTH+FBITS bits); root=0, remainder=0. Go to SQRT with count=(WIDTH+FBITS)/2.
- SQRT state: per cycle, bring down the next 2 radicand bits; trial = (root<<2)|1. If remainder >= trial: subtract it and root=(root<<1)|1; else root=root<<1. This is an unsigned compare; no sign test on the raw difference.
- SQRT end: result <= zero-extended root, equal to floor(sqrt(operand_1 * 2^FBITS)). Latency (WIDTH+FBITS)/2+1.
- DONE: ready=1, busy=0 for exactly one cycle, then IDLE. A start that arrives in DONE is ignored.
- busy=1 in MUL and SQRT only.
- Operand 0 for MUL/SQRT produces result 0 with normal latency; there is no early exit.

Optional Feature:
FIXED_POINT_SATURATE_EN
- Defined:
  - ADD carry-out forces result to all-ones.
  - SUB borrow forces result to 0.
  - MUL with any nonzero product bit above WIDTH+FBITS-1 forces result to all-ones.
  - SQRT is unaffected. Latencies are unchanged.
- Undefined: wrap/truncate exactly as in Behaviour, and the overflow-detect logic is absent.

Decomposition:
- Shared defines header holds the FPU_ADD/SUB/MUL/SQRT encodings and the state encodings (IDLE/MUL/SQRT/DONE).
- Sub-module fixed_point_sqrt_step: combinational single iteration. Inputs remainder, root, 2-bit pair. Outputs next remainder and next root. The top level owns the counter and registers.

Test Plan:
- ADD 0x00000800 + 0x00000C00 (2.0+3.0) -> ready after 1 cycle, result 0x00001400. SUB 0x00000400 - 0x00000800 -> 0xFFFFFC00 (wrap).
- MUL 2048 * 3072 (2.0*3.0) -> ready exactly 33 cycles after start, result 6144 (6.0). busy high for cycles 1..32.
- SQRT 4096 (4.0) -> 2048 after 22 cycles. SQRT 2048 (2.0) -> 1448. SQRT 0 -> 0 after 22 cycles.
- Second start pulse mid-MUL with different operands -> ignored; the single ready carries the first result. Reset asserted at cycle 10 of SQRT -> ready never pulses, busy=0 and result=0 next cycle.
- Overflow: ADD 0xFFFFFFFF+1 -> 0x00000000 without the macro, 0xFFFFFFFF with FIXED_POINT_SATURATE_EN. MUL 0x01000000*0x01000000 -> 0x00000000 without the macro, 0xFFFFFFFF with it.
- Parameter sweep WIDTH=16, FBITS=8: MUL 0x0180*0x0200 (1.5*2.0) -> 0x0300 after 17 cycles; SQRT 0x0900 (9.0) -> 0x0300 after 13 cycles.

Source files
------------

// File: rtl/fixed_point_seq_unit_pkg.sv
// Shared encodings for the multi-cycle fixed-point unit: operation codes and FSM states.
package fixed_point_seq_unit_pkg;

    typedef enum logic [1:0] {
        FPU_ADD  = 2'd0,
        FPU_SUB  = 2'd1,
        FPU_MUL  = 2'd2,
        FPU_SQRT = 2'd3
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_SQRT = 2'd2,
        ST_DONE = 2'd3
    } fpu_state_e;

endpackage

// File: rtl/fixed_point_sqrt_step.sv
// One digit-by-digit square-root iteration: brings down a bit pair and resolves one root bit.
module fixed_point_sqrt_step #(
    parameter int RTW = 21
) (
    input  logic [RTW+1:0] i_rem,
    input  logic [RTW-1:0] i_root,
    input  logic [1:0]     i_pair,
    output logic [RTW+1:0] o_rem,
    output logic [RTW-1:0] o_root
);

    localparam int RW = RTW + 2;

    logic [RW+1:0] w_shifted;
    logic [RW+1:0] w_trial;
    logic          w_ge;

    // Remainder stays below 2^RTW before each shift, so the wide view never loses bits.
    assign w_shifted = {i_rem, i_pair};
    assign w_trial   = {2'b00, i_root, 2'b01};
    assign w_ge      = (w_shifted >= w_trial);

    assign o_rem  = w_ge ? RW'(w_shifted - w_trial) : RW'(w_shifted);
    assign o_root = {i_root[RTW-2:0], w_ge};

endmodule

// File: rtl/fixed_point_seq_unit.sv
// Multi-cycle unsigned Q fixed-point ADD/SUB/MUL/SQRT with start/busy/ready handshake.
// Optional build macro FIXED_POINT_SATURATE_EN selects saturating ADD/SUB/MUL instead of wrap/truncate.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | waiting for start; ADD/SUB resolve here
//   ST_MUL  | shift-add, one multiplier bit per cycle
//   ST_SQRT | one root bit per cycle
//   ST_DONE | ready pulse, result valid, back to idle
module fixed_point_seq_unit
    import fixed_point_seq_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FBITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       operation,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic [WIDTH-1:0] result,
    output logic             ready,
    output logic             busy
);

    localparam int NW  = WIDTH + FBITS;
    localparam int RTW = NW / 2;
    localparam int RW  = RTW + 2;
    localparam int CW  = $clog2(((WIDTH > RTW) ? WIDTH : RTW) + 1);
`ifdef FIXED_POINT_SATURATE_EN
    localparam int AW  = 2 * WIDTH;
`else
    localparam int AW  = NW;
`endif

    if (((NW % 2) != 0) || (WIDTH < 8) || (FBITS < 1) || (FBITS >= WIDTH)) begin : g_bad_params
        $error("fixed_point_seq_unit: WIDTH+FBITS must be even, WIDTH>=8, 0<FBITS<WIDTH");
    end

    fpu_state_e       r_state;
    fpu_state_e       w_state_next;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [AW-1:0]    r_acc;
    logic [NW-1:0]    r_rad;
    logic [RW-1:0]    r_rem;
    logic [RTW-1:0]   r_root;
    logic [WIDTH-1:0] r_result;

    logic             w_last;
    logic [AW-1:0]    w_acc_next;
    logic [RW-1:0]    w_rem_next;
    logic [RTW-1:0]   w_root_next;
    logic [WIDTH-1:0] w_add_res;
    logic [WIDTH-1:0] w_sub_res;
    logic [WIDTH-1:0] w_mul_res;

    assign w_last     = (r_count == CW'(1));
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef FIXED_POINT_SATURATE_EN
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum     = {1'b0, operand_1} + {1'b0, operand_2};
    assign w_diff    = {1'b0, operand_1} - {1'b0, operand_2};
    assign w_add_res = w_sum[WIDTH]  ? '1 : w_sum[WIDTH-1:0];
    assign w_sub_res = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
    assign w_mul_res = (|w_acc_next[AW-1:NW]) ? '1 : w_acc_next[NW-1:FBITS];
`else
    assign w_add_res = operand_1 + operand_2;
    assign w_sub_res = operand_1 - operand_2;
    assign w_mul_res = w_acc_next[NW-1:FBITS];
`endif

    fixed_point_sqrt_step #(
        .RTW (RTW)
    ) u_sqrt_step (
        .i_rem  (r_rem),
        .i_root (r_root),
        .i_pair (r_rad[NW-1:NW-2]),
        .o_rem  (w_rem_next),
        .o_root (w_root_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        ready        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (fpu_op_e'(operation))
                        FPU_MUL:  w_state_next = ST_MUL;
                        FPU_SQRT: w_state_next = ST_SQRT;
                        default:  w_state_next = ST_DONE;
                    endcase
                end
            end
            ST_MUL, ST_SQRT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                ready        = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_rad    <= '0;
            r_rem    <= '0;
            r_root   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (fpu_op_e'(operation))
                            FPU_ADD: r_result <= w_add_res;
                            FPU_SUB: r_result <= w_sub_res;
                            FPU_MUL: begin
                                r_mcand  <= AW'(operand_1);
                                r_mplier <= operand_2;
                                r_acc    <= '0;
                                r_count  <= CW'(WIDTH);
                            end
                            default: begin
                                r_rad   <= {operand_1, {FBITS{1'b0}}};
                                r_rem   <= '0;
                                r_root  <= '0;
                                r_count <= CW'(RTW);
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - CW'(1);
                    if (w_last) begin
                        r_result <= w_mul_res;
                    end
                end
                ST_SQRT: begin
                    r_rem   <= w_rem_next;
                    r_root  <= w_root_next;
                    r_rad   <= r_rad << 2;
                    r_count <= r_count - CW'(1);
                    if (w_last) begin
                        r_result <= WIDTH'(w_root_next);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_fixed_point_seq_unit.sv
// Directed-vector bench for fixed_point_seq_unit at 32/10 and 16/8 geometries.
module tb_fixed_point_seq_unit;
    import fixed_point_seq_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        s32, s16;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] res32;
    logic        rdy32, bsy32;
    logic [15:0] res16;
    logic        rdy16, bsy16;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FIXED_POINT_SATURATE_EN
    localparam logic [31:0] EXP_SUB     = 32'h0000_0000;
    localparam logic [31:0] EXP_ADD_OVF = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_MUL_OVF = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] EXP_SUB     = 32'hFFFF_FC00;
    localparam logic [31:0] EXP_ADD_OVF = 32'h0000_0000;
    localparam logic [31:0] EXP_MUL_OVF = 32'h0000_0000;
`endif

    always #5 clk = ~clk;

    fixed_point_seq_unit u_dut32 (
        .clk       (clk),
        .reset     (reset),
        .start     (s32),
        .operation (op),
        .operand_1 (a),
        .operand_2 (b),
        .result    (res32),
        .ready     (rdy32),
        .busy      (bsy32)
    );

    fixed_point_seq_unit #(
        .WIDTH (16),
        .FBITS (8)
    ) u_dut16 (
        .clk       (clk),
        .reset     (reset),
        .start     (s16),
        .operation (op),
        .operand_1 (a[15:0]),
        .operand_2 (b[15:0]),
        .result    (res16),
        .ready     (rdy16),
        .busy      (bsy16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one operation, scrambles the inputs after acceptance, and waits for ready.
    task automatic run_op(input bit w16, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output int lat, output int busy_bad);
        @(negedge clk);
        op = o; a = x; b = y;
        if (w16) s16 = 1'b1; else s32 = 1'b1;
        @(posedge clk);
        #1;
        s16 = 1'b0; s32 = 1'b0;
        a = ~x; b = ~y; op = ~o;
        lat = 0; busy_bad = 0;
        while (lat < 200) begin
            lat++;
            @(negedge clk);
            if (w16 ? rdy16 : rdy32) begin
                if (w16 ? bsy16 : bsy32) busy_bad++;
                break;
            end
            if (!(w16 ? bsy16 : bsy32)) busy_bad++;
        end
        r = w16 ? {16'h0000, res16} : res32;
    endtask

    task automatic do_test(input string tag, input bit w16, input logic [1:0] o,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp_r, input int exp_lat);
        logic [31:0] r;
        int lat, busy_bad;
        run_op(w16, o, x, y, r, lat, busy_bad);
        check({tag, "_result"}, r, exp_r);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busy_bad), 32'd0);
    endtask

    initial begin
        int pulses, first;
        logic [31:0] r;
        int lat, busy_bad;

        reset = 1'b1; s32 = 1'b0; s16 = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", res32, 32'd0);
        check("rst_ready", {31'd0, rdy32}, 32'd0);
        check("rst_busy", {31'd0, bsy32}, 32'd0);
        reset = 1'b0;

        do_test("add",      1'b0, FPU_ADD,  32'h0000_0800, 32'h0000_0C00, 32'h0000_1400, 1);
        do_test("sub",      1'b0, FPU_SUB,  32'h0000_0400, 32'h0000_0800, EXP_SUB, 1);
        do_test("mul",      1'b0, FPU_MUL,  32'd2048, 32'd3072, 32'd6144, 33);
        do_test("mul_zero", 1'b0, FPU_MUL,  32'd0, 32'd3072, 32'd0, 33);
        do_test("sqrt4",    1'b0, FPU_SQRT, 32'd4096, 32'd0, 32'd2048, 22);
        do_test("sqrt2",    1'b0, FPU_SQRT, 32'd2048, 32'd5, 32'd1448, 22);
        do_test("sqrt0",    1'b0, FPU_SQRT, 32'd0, 32'd0, 32'd0, 22);
        do_test("add_ovf",  1'b0, FPU_ADD,  32'hFFFF_FFFF, 32'd1, EXP_ADD_OVF, 1);
        do_test("mul_ovf",  1'b0, FPU_MUL,  32'h0100_0000, 32'h0100_0000, EXP_MUL_OVF, 33);
        do_test("mul16",    1'b1, FPU_MUL,  32'h0000_0180, 32'h0000_0200, 32'h0000_0300, 17);
        do_test("sqrt16",   1'b1, FPU_SQRT, 32'h0000_0900, 32'd0, 32'h0000_0300, 13);

        // Second start mid-MUL must be dropped.
        @(negedge clk);
        op = FPU_MUL; a = 32'd2048; b = 32'd3072; s32 = 1'b1;
        @(posedge clk);
        #1 s32 = 1'b0;
        pulses = 0; first = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (rdy32) begin
                pulses++;
                if (first == 0) first = c;
            end
            if (c == 5) begin
                op = FPU_ADD; a = 32'd5; b = 32'd7; s32 = 1'b1;
            end else begin
                s32 = 1'b0;
            end
        end
        check("midmul_pulses", 32'(pulses), 32'd1);
        check("midmul_cycle", 32'(first), 32'd33);
        check("midmul_result", res32, 32'd6144);

        // Start arriving while in DONE is ignored.
        run_op(1'b0, FPU_ADD, 32'd1, 32'd2, r, lat, busy_bad);
        check("done_first", r, 32'd3);
        op = FPU_ADD; a = 32'd10; b = 32'd20; s32 = 1'b1;
        @(posedge clk);
        #1 s32 = 1'b0;
        @(negedge clk);
        check("done_start_ready", {31'd0, rdy32}, 32'd0);
        check("done_start_busy", {31'd0, bsy32}, 32'd0);
        check("done_start_result", res32, 32'd3);
        @(negedge clk);
        check("done_start_ready2", {31'd0, rdy32}, 32'd0);

        // Reset in cycle 10 of SQRT aborts with no ready pulse.
        @(negedge clk);
        op = FPU_SQRT; a = 32'd4096; b = 32'd0; s32 = 1'b1;
        @(posedge clk);
        #1 s32 = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        check("abort_busy_before", {31'd0, bsy32}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, bsy32}, 32'd0);
        check("abort_ready", {31'd0, rdy32}, 32'd0);
        check("abort_result", res32, 32'd0);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rdy32) pulses++;
        end
        check("abort_no_ready", 32'(pulses), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
